mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single C2 memory bus (C2_NOP/C2_READ_LINE/C2_WRITE_LINE/C2_RESPONSE) between NREQ line-level requesters.
//  Round-robin grant; latches request, serialises write lines into BEATS bus beats, collects read beats into a line.
//  Sits between cache/DMA clients and Memory; top level turns mem_drive/mem_*_out/mem_*_in into the inout cmd_w/data_w.
// PARAMETERS
//  NREQ     2                                  number of requesters (2..4)
//  ADDR_W   addr2_bus_size*BITS_IN_BYTE        line-address width
//  DATA_W   data2_bus_size*BITS_IN_BYTE        bus beat width
//  LINE_W   cache_line_size*BITS_IN_BYTE       line width; BEATS = LINE_W/DATA_W (>=1)
//  TIMEOUT  255                                max cycles READ_LINE -> first C2_RESPONSE
// PORTS
//  clk           in   1              clock (all state on posedge)
//  reset         in   1              synchronous, active-high
//  req           in   NREQ           request per client; held until its ack
//  req_we        in   NREQ           1 = write line, 0 = read line
//  req_addr      in   NREQ*ADDR_W    line address, slice i = client i
//  req_wline     in   NREQ*LINE_W    write line, slice i = client i, beat k = bits [k*DATA_W +: DATA_W]
//  ack           out  NREQ           1-cycle pulse: request i latched
//  done          out  1              1-cycle pulse: transaction finished
//  done_id       out  $clog2(NREQ)   client owning done
//  err           out  1              valid with done: read timed out
//  rline         out  LINE_W         read line, valid with done (reads only)
//  busy          out  1              state != IDLE
//  mem_addr      out  ADDR_W         address to Memory
//  mem_cmd_out   out  2              command driven when mem_drive=1
//  mem_data_out  out  DATA_W         beat driven when mem_drive=1
//  mem_drive     out  1              arbiter owns cmd/data bus
//  mem_cmd_in    in   2              resolved cmd bus
//  mem_data_in   in   DATA_W         resolved data bus
// BEHAVIOUR
//  Reset (sync): state=IDLE, rr_ptr=0, ack=0, done=0, err=0, done_id=0, rline=0, busy=0,
//   mem_drive=1, mem_cmd_out=C2_NOP, mem_addr=0, mem_data_out=0. Mid-transaction reset abandons it silently (no done);
//   Memory is reset alongside.
//  States: IDLE -> (WRITE | RD_CMD) ; WRITE -> GAP ; RD_CMD -> RD_WAIT -> RD_BEATS -> GAP ; RD_WAIT -> GAP (timeout) ; GAP -> IDLE.
//  IDLE: pick first i with req[i]=1 scanning rr_ptr, rr_ptr+1, ... mod NREQ. Latch we/addr/wline/id; ack[i]=1;
//   rr_ptr <= i+1 mod NREQ. No req -> stay, drive C2_NOP.
//  WRITE: BEATS cycles; cycle k: mem_drive=1, cmd=C2_WRITE_LINE, data=beat k, addr held. Then GAP with done=1.
//  RD_CMD: 1 cycle cmd=C2_READ_LINE, mem_drive=1. RD_WAIT: mem_drive=0, count cycles; first posedge with
//   mem_cmd_in==C2_RESPONSE captures beat 0 -> RD_BEATS. Counter reaching TIMEOUT -> err=1, done=1, rline=0, -> GAP.
//  RD_BEATS: captures beats 1..BEATS-1 on consecutive posedges into rline[k*DATA_W +: DATA_W]; after last beat
//   done=1, rline valid -> GAP. BEATS=1 goes RD_WAIT -> GAP directly.
//  GAP: 1 cycle, mem_drive=1, cmd=C2_NOP (bus turnaround; Memory releases on the same edge).
//  ack and done never in the same cycle; at most one outstanding transaction; req dropped before ack = withdrawn.
//  Latency: IDLE grant to done = BEATS+1 cycles (write); 2 + mem wait + BEATS cycles (read).
//  done_id/rline/err hold until next done; mem_addr holds last value in IDLE.
// TESTING
//  1. Reset, req=00 for 10 cycles -> ack=0, done=0, mem_cmd_out=C2_NOP, mem_drive=1 every cycle.
//  2. Client0 write addr 5, line 0x..0102 -> ack[0] once, BEATS cycles of C2_WRITE_LINE with beats in order, done, done_id=0;
//     then client1 read addr 5 -> rline equals written line, done_id=1.
//  3. req=11 held continuously -> grants alternate 0,1,0,1 over 4 transactions; no client granted twice in a row.
//  4. Read with Memory delay 99 time units -> mem_drive=0 from cycle after READ_LINE until done; done exactly BEATS-1 cycles
//     after first C2_RESPONSE edge.
//  5. Read with no Memory attached (mem_cmd_in=2'bzz) -> done=1, err=1, rline=0 TIMEOUT+2 cycles after ack; next req served.
//  6. Assert reset during 2nd beat of write -> next cycle IDLE, busy=0, no done; subsequent read to same addr completes err=0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of the C2 memory bus between NREQ line-level requesters.
// Write lines go out as BEATS consecutive beats; read beats are gathered back into one line.
module mem_bus_arbiter #(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int LINE_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*LINE_W-1:0]   req_wline,
    output logic [NREQ-1:0]          ack,
    output logic                     done,
    output logic [$clog2(NREQ)-1:0]  done_id,
    output logic                     err,
    output logic [LINE_W-1:0]        rline,
    output logic                     busy,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [1:0]               mem_cmd_out,
    output logic [DATA_W-1:0]        mem_data_out,
    output logic                     mem_drive,
    input  logic [1:0]               mem_cmd_in,
    input  logic [DATA_W-1:0]        mem_data_in
);
    localparam int BEATS = LINE_W / DATA_W;
    localparam int IW    = $clog2(NREQ);
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int CW    = $clog2(TIMEOUT + 1);

    localparam logic [1:0] C2_NOP        = 2'd0;
    localparam logic [1:0] C2_RESPONSE   = 2'd1;
    localparam logic [1:0] C2_READ_LINE  = 2'd2;
    localparam logic [1:0] C2_WRITE_LINE = 2'd3;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WRITE    = 3'd1;
    localparam logic [2:0] S_RD_CMD   = 3'd2;
    localparam logic [2:0] S_RD_WAIT  = 3'd3;
    localparam logic [2:0] S_RD_BEATS = 3'd4;
    localparam logic [2:0] S_GAP      = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [IW-1:0]     rr_q, rr_d, id_q, id_d, done_id_q, done_id_d, gnt;
    logic              we_q, we_d, err_q, err_d, found, last;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wline_q, wline_d, line_q, line_d, rline_q, rline_d, line_cap;
    logic [BW-1:0]     beat_q, beat_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Scan downwards so the requester closest to rr_q is the one left standing.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int o = NREQ - 1; o >= 0; o--) begin
            if (req[(int'(rr_q) + o) % NREQ]) begin
                gnt   = IW'((int'(rr_q) + o) % NREQ);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        id_d      = id_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wline_d   = wline_q;
        line_d    = line_q;
        beat_d    = beat_q;
        cnt_d     = cnt_q;
        done_id_d = done_id_q;
        err_d     = err_q;
        rline_d   = rline_q;
        line_cap  = line_q;
        line_cap[beat_q*DATA_W +: DATA_W] = mem_data_in;
        last      = beat_q == BW'(BEATS - 1);
        case (state_q)
            S_IDLE: if (found) begin
                state_d = req_we[gnt] ? S_WRITE : S_RD_CMD;
                rr_d    = IW'((int'(gnt) + 1) % NREQ);
                id_d    = gnt;
                we_d    = req_we[gnt];
                addr_d  = req_addr[gnt*ADDR_W +: ADDR_W];
                wline_d = req_wline[gnt*LINE_W +: LINE_W];
                beat_d  = '0;
                cnt_d   = '0;
            end
            S_WRITE: begin
                beat_d = beat_q + 1'b1;
                if (last) begin
                    state_d   = S_GAP;
                    done_id_d = id_q;
                    err_d     = 1'b0;
                end
            end
            S_RD_CMD: state_d = S_RD_WAIT;
            S_RD_WAIT: if (mem_cmd_in == C2_RESPONSE) begin
                line_d  = line_cap;
                beat_d  = beat_q + 1'b1;
                state_d = last ? S_GAP : S_RD_BEATS;
                if (last) begin
                    done_id_d = id_q;
                    err_d     = 1'b0;
                    rline_d   = line_cap;
                end
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                state_d   = S_GAP;
                done_id_d = id_q;
                err_d     = 1'b1;
                rline_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            S_RD_BEATS: begin
                line_d = line_cap;
                beat_d = beat_q + 1'b1;
                if (last) begin
                    state_d   = S_GAP;
                    done_id_d = id_q;
                    err_d     = 1'b0;
                    rline_d   = line_cap;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            id_q      <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wline_q   <= '0;
            line_q    <= '0;
            beat_q    <= '0;
            cnt_q     <= '0;
            done_id_q <= '0;
            err_q     <= 1'b0;
            rline_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            id_q      <= id_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wline_q   <= wline_d;
            line_q    <= line_d;
            beat_q    <= beat_d;
            cnt_q     <= cnt_d;
            done_id_q <= done_id_d;
            err_q     <= err_d;
            rline_q   <= rline_d;
        end
    end

    // ack and done are gated by reset so a cycle that is being reset reports nothing.
    assign ack          = (state_q == S_IDLE && found && !reset) ? NREQ'(1) << gnt : '0;
    assign done         = state_q == S_GAP && !reset;
    assign busy         = state_q != S_IDLE;
    assign mem_drive    = !(state_q == S_RD_WAIT || state_q == S_RD_BEATS);
    assign mem_cmd_out  = state_q == S_WRITE ? C2_WRITE_LINE : state_q == S_RD_CMD ? C2_READ_LINE : C2_NOP;
    assign mem_data_out = state_q == S_WRITE ? wline_q[beat_q*DATA_W +: DATA_W] : '0;
    assign mem_addr     = addr_q;
    assign done_id      = done_id_q;
    assign err          = err_q;
    assign rline        = rline_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: random and directed traffic against a transaction-level arbiter model
// with a behavioural C2 memory on the bus side.
module tb_mem_bus_arbiter;
    localparam int NREQ  = 2;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int LW    = 64;
    localparam int TO    = 255;
    localparam int BEATS = LW / DW;
    localparam logic [1:0] NOP = 2'd0, RESP = 2'd1, RD = 2'd2, WR = 2'd3;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NREQ-1:0]        req = '0, req_we = '0;
    logic [NREQ*AW-1:0]     req_addr = '0;
    logic [NREQ*LW-1:0]     req_wline = '0;
    logic [NREQ-1:0]        ack;
    logic                   done, err, busy, mem_drive;
    logic [$clog2(NREQ)-1:0] done_id;
    logic [LW-1:0]          rline;
    logic [AW-1:0]          mem_addr;
    logic [1:0]             mem_cmd_out;
    logic [DW-1:0]          mem_data_out;
    logic [1:0]             mem_cmd_in = NOP;
    logic [DW-1:0]          mem_data_in = '0;

    mem_bus_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .LINE_W(LW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wline(req_wline), .ack(ack), .done(done), .done_id(done_id), .err(err),
        .rline(rline), .busy(busy), .mem_addr(mem_addr), .mem_cmd_out(mem_cmd_out),
        .mem_data_out(mem_data_out), .mem_drive(mem_drive), .mem_cmd_in(mem_cmd_in),
        .mem_data_in(mem_data_in)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] dflt(logic [AW-1:0] a);
        return {a, ~a, a ^ 16'h5a5a, a + 16'd1};
    endfunction

    // Reference model: which client is granted, and what each transaction must produce.
    logic [LW-1:0] ref_mem [logic [AW-1:0]];
    int            cyc = 0, rr = 0, nacks = 0, t_id, t_ack, resp;
    bit            txn = 0, t_we, t_to, mem_off = 0;
    logic [AW-1:0] t_addr;
    logic [LW-1:0] t_line;
    bit            acked [NREQ];
    int            gseq [$];
    int            mem_delay = 0;

    always @(negedge clk) begin : mon
        int  k, g;
        bit  exp_done;
        cyc++;
        if (reset) begin
            txn = 0;
            rr  = 0;
        end else if (txn) begin
            k = cyc - t_ack;
            chk("ack_in_txn", 64'(ack), 0);
            chk("busy_txn", 64'(busy), 1);
            chk("mem_addr", 64'(mem_addr), 64'(t_addr));
            if (t_we) begin
                exp_done = k == BEATS + 1;
                if (k <= BEATS) begin
                    chk("wr_cmd", 64'(mem_cmd_out), 64'(WR));
                    chk("wr_drive", 64'(mem_drive), 1);
                    chk("wr_beat", 64'(mem_data_out), 64'(t_line[(k-1)*DW +: DW]));
                end
            end else begin
                if (k >= 2 && resp < 0 && mem_cmd_in === RESP) resp = cyc;
                exp_done = t_to ? (k == TO + 2) : (resp >= 0 && cyc == resp + BEATS);
                if (k == 1) begin
                    chk("rd_cmd", 64'(mem_cmd_out), 64'(RD));
                    chk("rd_cmd_drive", 64'(mem_drive), 1);
                end else if (!exp_done) begin
                    chk("rd_released", 64'(mem_drive), 0);
                end
            end
            chk("done", 64'(done), 64'(exp_done));
            if (exp_done) begin
                chk("gap_cmd", 64'(mem_cmd_out), 64'(NOP));
                chk("gap_drive", 64'(mem_drive), 1);
                chk("done_id", 64'(done_id), 64'(t_id));
                chk("err", 64'(err), 64'(t_to));
                if (t_we) ref_mem[t_addr] = t_line;
                else chk("rline", rline, t_to ? 64'd0 : t_line);
                txn = 0;
            end else if (k > TO + BEATS + 20) begin
                chk("txn_stuck", 64'(done), 1);
                txn = 0;
            end
        end else begin
            g = -1;
            for (int o = 0; o < NREQ; o++)
                if (g < 0 && req[(rr + o) % NREQ]) g = (rr + o) % NREQ;
            chk("ack", 64'(ack), g >= 0 ? 64'(1) << g : 64'd0);
            chk("busy_idle", 64'(busy), 0);
            chk("done_idle", 64'(done), 0);
            chk("idle_cmd", 64'(mem_cmd_out), 64'(NOP));
            chk("idle_drive", 64'(mem_drive), 1);
            if (g >= 0) begin
                txn    = 1;
                t_id   = g;
                t_we   = req_we[g];
                t_addr = req_addr[g*AW +: AW];
                t_line = t_we ? req_wline[g*LW +: LW] : (ref_mem.exists(t_addr) ? ref_mem[t_addr] : dflt(t_addr));
                t_to   = mem_off && !t_we;
                t_ack  = cyc;
                resp   = -1;
                rr     = (g + 1) % NREQ;
                acked[g] = 1;
                nacks++;
                gseq.push_back(g);
            end
        end
    end

    // Behavioural memory: stores written lines, answers reads after mem_delay idle cycles.
    logic [DW+1:0] mq [$];
    logic [LW-1:0] mstore [logic [AW-1:0]];
    logic [LW-1:0] wbuf = '0;
    int            wcnt = 0;

    always begin : memm
        logic [DW+1:0] nx;
        logic [LW-1:0] l;
        @(negedge clk);
        nx = {NOP, {DW{1'b0}}};
        if (reset) begin
            mq.delete();
            wcnt = 0;
        end else begin
            if (mem_drive && mem_cmd_out == WR) begin
                wbuf[wcnt*DW +: DW] = mem_data_out;
                wcnt++;
                if (wcnt == BEATS) begin
                    mstore[mem_addr] = wbuf;
                    wcnt = 0;
                end
            end
            if (mem_drive && mem_cmd_out == RD && !mem_off) begin
                l = mstore.exists(mem_addr) ? mstore[mem_addr] : dflt(mem_addr);
                repeat (mem_delay) mq.push_back({NOP, {DW{1'b0}}});
                for (int k = 0; k < BEATS; k++) mq.push_back({RESP, l[k*DW +: DW]});
            end
            if (mq.size() > 0) nx = mq.pop_front();
        end
        @(posedge clk);
        #1;
        mem_cmd_in  = mem_off ? 2'bzz : nx[DW +: 2];
        mem_data_in = mem_off ? 'z : nx[DW-1:0];
    end

    task automatic issue(int i, bit we, logic [AW-1:0] a, logic [LW-1:0] l);
        int n = 0;
        @(posedge clk);
        #1;
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_wline[i*LW +: LW] = l;
        acked[i] = 0;
        req[i] = 1'b1;
        while (!acked[i] && n < 700) begin
            @(posedge clk);
            n++;
        end
        if (!acked[i]) chk("ack_wait", 64'(ack), 64'(1) << i);
        #1;
        req[i] = 1'b0;
        acked[i] = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(posedge clk);
        while (txn && n < 700) begin
            @(posedge clk);
            n++;
        end
        if (txn) chk("idle_wait", 64'(busy), 0);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int base, n;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_done_id", 64'(done_id), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_rline", rline, 0);
        chk("rst_mem_addr", 64'(mem_addr), 0);
        chk("rst_data_out", 64'(mem_data_out), 0);
        repeat (10) @(posedge clk);

        issue(0, 1'b1, 16'd5, 64'h1122_3344_5566_0102);
        wait_idle();
        issue(1, 1'b0, 16'd5, '0);
        wait_idle();
        chk("rd_after_wr", rline, 64'h1122_3344_5566_0102);
        chk("rd_after_wr_id", 64'(done_id), 1);

        pulse_reset();
        base = gseq.size();
        n = 0;
        @(posedge clk);
        #1;
        req_we = '0;
        req_addr = {16'd2, 16'd1};
        acked[0] = 0;
        acked[1] = 0;
        req = '1;
        while (nacks < base + 4 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1 req = '0;
        acked[0] = 0;
        acked[1] = 0;
        wait_idle();
        if (gseq.size() < base + 4) chk("alt_count", 64'(gseq.size()), 64'(base + 4));
        else for (int k = 0; k < 4; k++) chk("alternate", 64'(gseq[base+k]), 64'(k % 2));

        mem_delay = 10;
        issue(0, 1'b0, 16'd5, '0);
        wait_idle();
        mem_delay = 0;

        mem_off = 1;
        issue(0, 1'b0, 16'd2, '0);
        wait_idle();
        chk("timeout_err", 64'(err), 1);
        chk("timeout_rline", rline, 0);
        mem_off = 0;
        @(posedge clk);
        issue(1, 1'b1, 16'd7, 64'h0bad_f00d_1234_5678);
        wait_idle();
        chk("after_timeout_err", 64'(err), 0);
        chk("after_timeout_id", 64'(done_id), 1);

        issue(0, 1'b1, 16'd3, 64'hcafe_babe_dead_beef);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_done", 64'(done), 0);
        issue(1, 1'b0, 16'd3, '0);
        wait_idle();
        chk("mid_rst_rline", rline, dflt(16'd3));
        chk("mid_rst_err", 64'(err), 0);

        repeat (3000) begin
            @(posedge clk);
            #1;
            mem_delay = $urandom_range(0, 8);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && acked[i]) begin
                    req[i] = 1'b0;
                    acked[i] = 0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req_we[i] = 1'($urandom_range(0, 1));
                    req_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
                    req_wline[i*LW +: LW] = {$urandom, $urandom};
                    acked[i] = 0;
                    req[i] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1 req = '0;
        acked[0] = 0;
        acked[1] = 0;
        wait_idle();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
